// File: rtl/cfg_cnt_pkg.sv
// Shared encodings for the configurable up/down counter: boundary modes,
// control FSM states and the mode decode used when capturing mode_q.
package cfg_cnt_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } cnt_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } cnt_state_e;

    // The unused encoding 2'b11 behaves as wrap, so it is folded at capture time.
    function automatic cnt_mode_e decode_mode(input logic [1:0] m);
        if (m == 2'b11) begin
            return MODE_WRAP;
        end
        return cnt_mode_e'(m);
    endfunction

endpackage

// File: rtl/cnt_step_calc.sv
// Combinational next-count calculation for one active cycle. Computes the
// raw result in a widened signed domain so both directions can detect
// leaving [0, limit_q], then applies the wrap or clamp rule.
module cnt_step_calc
    import cfg_cnt_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [WIDTH-1:0]  limit_q,
    input  logic [STEP_W-1:0] s,
    input  logic              up,
    input  cnt_mode_e         mode,
    output logic [WIDTH-1:0]  next_count,
    output logic              out_of_range
);

    // Two extra bits: one for the carry of count + s, one for the sign of count - s.
    localparam int EW = WIDTH + 2;

    logic signed [EW-1:0] cnt_x;
    logic signed [EW-1:0] lim_x;
    logic signed [EW-1:0] s_x;
    logic signed [EW-1:0] raw_up;
    logic signed [EW-1:0] raw_dn;
    logic signed [EW-1:0] wrap_up;
    logic signed [EW-1:0] wrap_dn;

    // Raw step results and their wrapped counterparts in the widened domain.
    always_comb begin
        cnt_x   = signed'({2'b00, count});
        lim_x   = signed'({2'b00, limit_q});
        s_x     = signed'(EW'(s));
        raw_up  = cnt_x + s_x;
        raw_dn  = cnt_x - s_x;
        wrap_up = raw_up - lim_x - EW'(1);
        wrap_dn = raw_dn + lim_x + EW'(1);
    end

    // Select the in-range result, or apply the boundary rule of the mode.
    always_comb begin
        next_count   = count;
        out_of_range = 1'b0;
        if (up) begin
            if (raw_up > lim_x) begin
                out_of_range = 1'b1;
                if (mode == MODE_WRAP) begin
                    next_count = WIDTH'(wrap_up);
                end else begin
                    next_count = limit_q;
                end
            end else begin
                next_count = WIDTH'(raw_up);
            end
        end else begin
            if (raw_dn[EW-1]) begin
                out_of_range = 1'b1;
                if (mode == MODE_WRAP) begin
                    next_count = WIDTH'(wrap_dn);
                end else begin
                    next_count = '0;
                end
            end else begin
                next_count = WIDTH'(raw_dn);
            end
        end
    end

endmodule

// File: rtl/cfg_updn_counter.sv
// Configurable up/down counter with programmable terminal value, step size
// and wrap / saturate / one-shot boundary behaviour. Terminal value and mode
// are latched only on clr or load; all outputs are registered.
module cfg_updn_counter
    import cfg_cnt_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  limit,
    input  logic [1:0]        mode,
    input  logic              act,
    input  logic              up_dwn_n,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              ovflw,
    output logic              undflw,
    output logic              done
);

    // A step larger than the range is clamped to the terminal value.
    function automatic logic [STEP_W-1:0] clamp_step(input logic [STEP_W-1:0] stp,
                                                     input logic [WIDTH-1:0]  lim);
        if (WIDTH'(stp) > lim) begin
            return STEP_W'(lim);
        end
        return stp;
    endfunction

    // A load value above the terminal value saturates to it.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val,
                                                    input logic [WIDTH-1:0] lim);
        return (val > lim) ? lim : val;
    endfunction

    cnt_state_e        state;
    cnt_state_e        state_nxt;
    cnt_mode_e         mode_q;
    cnt_mode_e         mode_nxt;
    logic [WIDTH-1:0]  limit_q;
    logic [WIDTH-1:0]  limit_nxt;
    logic [WIDTH-1:0]  count_nxt;
    logic              tc_nxt;
    logic              ovflw_nxt;
    logic              undflw_nxt;
    logic              done_nxt;

    logic [STEP_W-1:0] step_eff;
    logic [WIDTH-1:0]  calc_count;
    logic              calc_oor;
    logic              boundary;

    assign step_eff = clamp_step(step, limit_q);

    // With limit_q = 0 the clamped step is always zero, so any nonzero
    // requested step is counted as pushing against the boundary.
    assign boundary = calc_oor | ((limit_q == '0) && (step != '0));

    cnt_step_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_step_calc (
        .count        (count),
        .limit_q      (limit_q),
        .s            (step_eff),
        .up           (up_dwn_n),
        .mode         (mode_q),
        .next_count   (calc_count),
        .out_of_range (calc_oor)
    );

    // Next-state and next-output logic: clr beats load beats counting.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        tc_nxt     = 1'b0;
        ovflw_nxt  = ovflw;
        undflw_nxt = undflw;
        done_nxt   = done;
        limit_nxt  = limit_q;
        mode_nxt   = mode_q;

        if (clr) begin
            state_nxt  = ST_IDLE;
            count_nxt  = '0;
            ovflw_nxt  = 1'b0;
            undflw_nxt = 1'b0;
            done_nxt   = 1'b0;
            limit_nxt  = limit;
            mode_nxt   = decode_mode(mode);
        end else if (load) begin
            state_nxt  = ST_IDLE;
            count_nxt  = clamp_load(load_val, limit);
            done_nxt   = 1'b0;
            limit_nxt  = limit;
            mode_nxt   = decode_mode(mode);
        end else begin
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (act) begin
                        state_nxt = ST_RUN;
                        count_nxt = calc_count;
                        if (boundary) begin
                            tc_nxt = 1'b1;
                            if (up_dwn_n) begin
                                ovflw_nxt = 1'b1;
                            end else begin
                                undflw_nxt = 1'b1;
                            end
                            if (mode_q == MODE_ONESHOT) begin
                                state_nxt = ST_DONE;
                                done_nxt  = 1'b1;
                            end
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_DONE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, configuration and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            tc      <= 1'b0;
            ovflw   <= 1'b0;
            undflw  <= 1'b0;
            done    <= 1'b0;
            limit_q <= '1;
            mode_q  <= MODE_WRAP;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            tc      <= tc_nxt;
            ovflw   <= ovflw_nxt;
            undflw  <= undflw_nxt;
            done    <= done_nxt;
            limit_q <= limit_nxt;
            mode_q  <= mode_nxt;
        end
    end

endmodule

// File: tb/tb_cfg_updn_counter.sv
// Self-checking bench for cfg_updn_counter: directed scenarios followed by
// randomized traffic, all compared against an arithmetic reference model.
module tb_cfg_updn_counter;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] limit;
    logic [1:0] mode;
    logic       act;
    logic       up_dwn_n;
    logic [3:0] step;

    logic [7:0] count;
    logic       tc;
    logic       ovflw;
    logic       undflw;
    logic       done;

    logic [4:0] count5;
    logic       tc5;
    logic       ovflw5;
    logic       undflw5;
    logic       done5;

    int checks;
    int failures;

    // reference model state
    int m_count;
    int m_limit;
    int m_mode;
    bit m_tc;
    bit m_ov;
    bit m_un;
    bit m_done;

    int exp3_cnt[4];
    int exp3_tc[4];
    int exp5_cnt[4];
    int exp5_tc[4];

    cfg_updn_counter #(.WIDTH(8), .STEP_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .mode     (mode),
        .act      (act),
        .up_dwn_n (up_dwn_n),
        .step     (step),
        .count    (count),
        .tc       (tc),
        .ovflw    (ovflw),
        .undflw   (undflw),
        .done     (done)
    );

    cfg_updn_counter #(.WIDTH(5), .STEP_W(3)) dut5 (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (load),
        .load_val (load_val[4:0]),
        .limit    (limit[4:0]),
        .mode     (mode),
        .act      (act),
        .up_dwn_n (up_dwn_n),
        .step     (step[2:0]),
        .count    (count5),
        .tc       (tc5),
        .ovflw    (ovflw5),
        .undflw   (undflw5),
        .done     (done5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp, input bit obs_known);
        checks++;
        assert (obs_known && (obs === exp)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_count"},  int'(count),  m_count,   !$isunknown(count));
        check({tag, "_tc"},     int'(tc),     int'(m_tc),   !$isunknown(tc));
        check({tag, "_ovflw"},  int'(ovflw),  int'(m_ov),   !$isunknown(ovflw));
        check({tag, "_undflw"}, int'(undflw), int'(m_un),   !$isunknown(undflw));
        check({tag, "_done"},   int'(done),   int'(m_done), !$isunknown(done));
    endtask

    function automatic void model_reset();
        m_count = 0;
        m_limit = 255;
        m_mode  = 0;
        m_tc    = 1'b0;
        m_ov    = 1'b0;
        m_un    = 1'b0;
        m_done  = 1'b0;
    endfunction

    // Behaviour of one clock edge from the rules: range [0, limit], wrap is
    // modular arithmetic over limit+1 values, other modes clamp.
    function automatic void model_step();
        int  s;
        int  raw;
        int  span;
        bit  hit;
        m_tc = 1'b0;
        if (clr) begin
            m_count = 0;
            m_ov    = 1'b0;
            m_un    = 1'b0;
            m_done  = 1'b0;
            m_limit = int'(limit);
            m_mode  = int'(mode);
        end else if (load) begin
            m_count = (int'(load_val) > int'(limit)) ? int'(limit) : int'(load_val);
            m_limit = int'(limit);
            m_mode  = int'(mode);
            m_done  = 1'b0;
        end else if (act && !m_done) begin
            span = m_limit + 1;
            s    = (int'(step) > m_limit) ? m_limit : int'(step);
            raw  = up_dwn_n ? (m_count + s) : (m_count - s);
            hit  = (raw < 0) || (raw > m_limit) || ((m_limit == 0) && (step != 0));
            if (hit) begin
                m_tc = 1'b1;
                if (up_dwn_n) m_ov = 1'b1;
                else          m_un = 1'b1;
                if (m_mode == 1 || m_mode == 2) begin
                    m_count = up_dwn_n ? m_limit : 0;
                end else begin
                    m_count = ((raw % span) + span) % span;
                end
                if (m_mode == 2) m_done = 1'b1;
            end else begin
                m_count = raw;
            end
        end
    endfunction

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        model_step();
        check_all(tag);
    endtask

    task automatic idle_inputs();
        clr = 1'b0; load = 1'b0; act = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; limit = '0;
        mode = 2'b00; act = 1'b0; up_dwn_n = 1'b1; step = '0;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        tick("idle");

        // asynchronous reset while counting
        load = 1'b1; load_val = 8'd10; limit = 8'd255; mode = 2'b00;
        tick("t1_load");
        load = 1'b0; act = 1'b1; up_dwn_n = 1'b1; step = 4'd3;
        tick("t1_step");
        check("t1_count13", int'(count), 13, !$isunknown(count));
        act = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t1_async");
        #2;
        rst = 1'b0;
        repeat (3) tick("t1_after");

        // full wrap over 0..31, also on the 5-bit instance
        clr = 1'b1; limit = 8'd31; mode = 2'b00;
        tick("t2_clr");
        clr = 1'b0; act = 1'b1; up_dwn_n = 1'b1; step = 4'd1;
        for (int i = 1; i <= 32; i++) begin
            tick("t2_run");
            check("t2_w5_count", int'(count5), m_count, !$isunknown(count5));
            check("t2_w5_tc", int'(tc5), int'(m_tc), !$isunknown(tc5));
            check("t2_w5_ovflw", int'(ovflw5), int'(m_ov), !$isunknown(ovflw5));
            check("t2_expect_count", int'(count), i % 32, 1'b1);
            check("t2_expect_tc", int'(tc), (i == 32) ? 1 : 0, 1'b1);
        end
        check("t2_ovflw_sticky", int'(ovflw), 1, 1'b1);
        check("t2_w5_undflw", int'(undflw5), 0, !$isunknown(undflw5));
        check("t2_w5_done", int'(done5), 0, !$isunknown(done5));

        // wrap down with step 3, limit 9
        idle_inputs();
        clr = 1'b1; limit = 8'd9; mode = 2'b00;
        tick("t3_clr");
        clr = 1'b0; load = 1'b1; load_val = 8'd1;
        tick("t3_load");
        load = 1'b0; act = 1'b1; up_dwn_n = 1'b0; step = 4'd3;
        exp3_cnt = '{8, 5, 2, 9};
        exp3_tc  = '{1, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            tick("t3_run");
            check("t3_count", int'(count), exp3_cnt[i], 1'b1);
            check("t3_tc", int'(tc), exp3_tc[i], 1'b1);
        end
        check("t3_undflw", int'(undflw), 1, 1'b1);
        check("t3_ovflw", int'(ovflw), 0, 1'b1);

        // saturate at 20
        idle_inputs();
        clr = 1'b1; limit = 8'd20; mode = 2'b01;
        tick("t4_clr");
        clr = 1'b0; load = 1'b1; load_val = 8'd18;
        tick("t4_load");
        load = 1'b0; act = 1'b1; up_dwn_n = 1'b1; step = 4'd5;
        for (int i = 0; i < 3; i++) begin
            tick("t4_run");
            check("t4_count", int'(count), 20, 1'b1);
            check("t4_tc", int'(tc), 1, 1'b1);
        end
        check("t4_ovflw", int'(ovflw), 1, 1'b1);

        // one-shot up to 7
        idle_inputs();
        clr = 1'b1; limit = 8'd7; mode = 2'b10;
        tick("t5_clr");
        clr = 1'b0; act = 1'b1; up_dwn_n = 1'b1; step = 4'd2;
        exp5_cnt = '{2, 4, 6, 7};
        exp5_tc  = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            tick("t5_run");
            check("t5_count", int'(count), exp5_cnt[i], 1'b1);
            check("t5_tc", int'(tc), exp5_tc[i], 1'b1);
        end
        check("t5_done", int'(done), 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick("t5_hold");
            check("t5_hold_count", int'(count), 7, 1'b1);
            check("t5_hold_tc", int'(tc), 0, 1'b1);
        end
        act = 1'b0; load = 1'b1; load_val = 8'd3;
        tick("t5_reload");
        check("t5_reload_count", int'(count), 3, 1'b1);
        check("t5_reload_done", int'(done), 0, 1'b1);

        // clr + load + act together, then clamped load
        load = 1'b1; clr = 1'b1; act = 1'b1; load_val = 8'd200; limit = 8'd50;
        mode = 2'b00; step = 4'd5; up_dwn_n = 1'b1;
        tick("t6_clr_load");
        check("t6_count0", int'(count), 0, 1'b1);
        check("t6_ovflw0", int'(ovflw), 0, 1'b1);
        clr = 1'b0; act = 1'b0;
        tick("t6_load");
        check("t6_count50", int'(count), 50, 1'b1);
        load = 1'b0; act = 1'b1; step = 4'd1; limit = 8'd10;
        tick("t6_wrap_captured");
        check("t6_wrap_count", int'(count), 0, 1'b1);
        check("t6_wrap_tc", int'(tc), 1, 1'b1);

        // terminal value of zero
        idle_inputs();
        clr = 1'b1; limit = 8'd0; mode = 2'b01;
        tick("lim0_clr");
        clr = 1'b0; act = 1'b1; up_dwn_n = 1'b1; step = 4'd3;
        tick("lim0_up");
        check("lim0_up_tc", int'(tc), 1, 1'b1);
        step = 4'd0;
        tick("lim0_zero_step");
        check("lim0_zero_tc", int'(tc), 0, 1'b1);
        up_dwn_n = 1'b0; step = 4'd1;
        tick("lim0_down");
        check("lim0_undflw", int'(undflw), 1, 1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            clr      = (r < 3);
            load     = (r < 1) || (r >= 3 && r < 9);
            act      = ($urandom_range(0, 9) < 7);
            up_dwn_n = 1'($urandom_range(0, 1));
            step     = 4'($urandom_range(0, 15));
            load_val = 8'($urandom_range(0, 255));
            mode     = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       limit = 8'($urandom_range(0, 3));
                1:       limit = 8'($urandom_range(4, 20));
                2:       limit = 8'd255;
                default: limit = 8'($urandom_range(0, 255));
            endcase
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
